// File: rtl/ha_array_accumulator.sv
// ha_array_accumulator
// Final reduction stage behind the 8x8 half-adder-array partial-product
// generators. It combines four row-pair vectors into a 16-bit unsigned
// product, saturating at 16'hFFFF, through two valid/ready register stages.
// It also keeps a wrapping count of the products taken downstream.
module ha_array_accumulator #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       ha_array_0_b,
    input  logic [8:0]       ha_array_0_t,
    input  logic [6:0]       ha_array_1_b,
    input  logic [8:0]       ha_array_1_t,
    input  logic [6:0]       ha_array_2_b,
    input  logic [8:0]       ha_array_2_t,
    input  logic [6:0]       ha_array_3_b,
    input  logic [8:0]       ha_array_3_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      product,
    output logic             ovf,
    output logic [CNT_W-1:0] done_cnt
);

    // The value of one row pair, relative to that pair's own weight.
    // Carry bit j sits two places above sum bit j.
    function automatic logic [9:0] row_value(input logic [8:0] t, input logic [6:0] b);
        return 10'(t) + 10'({b, 2'b00});
    endfunction

    logic        s1_valid;
    logic [12:0] s01;
    logic [12:0] s23;
    logic        s2_valid;
    logic        adv1;
    logic        adv2;
    logic [9:0]  r0;
    logic [9:0]  r1;
    logic [9:0]  r2;
    logic [9:0]  r3;
    logic [16:0] p_sum;

    // A stage advances when it is empty or the stage after it advances.
    // With this rule a stalled output does not stall an empty s1.
    always_comb begin
        adv2 = !s2_valid || out_ready;
        adv1 = !s1_valid || adv2;
    end

    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    // Row values and the stage-2 sum, all unsigned with no truncation.
    // Row pair k+1 is worth four times row pair k.
    always_comb begin
        r0    = row_value(ha_array_0_t, ha_array_0_b);
        r1    = row_value(ha_array_1_t, ha_array_1_b);
        r2    = row_value(ha_array_2_t, ha_array_2_b);
        r3    = row_value(ha_array_3_t, ha_array_3_b);
        p_sum = 17'(s01) + 17'({s23, 4'b0000});
    end

    // Stage 1: combine the row pairs two at a time.
    // NOTE: state registers use non-blocking assignments, so every
    // always_ff reads the values from before the clock edge. Blocking
    // assignments here would let a stage see its neighbour's new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s01      <= '0;
            s23      <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            s01      <= 13'(r0) + 13'({r1, 2'b00});
            s23      <= 13'(r2) + 13'({r3, 2'b00});
        end
    end

    // Stage 2: final sum, saturated into 16 bits; held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            product  <= '0;
            ovf      <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            product  <= p_sum[16] ? 16'hFFFF : p_sum[15:0];
            ovf      <= p_sum[16];
        end
    end

    // Count products taken downstream; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (s2_valid && out_ready) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

endmodule
